// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the decode stage, the pipelined ALU and writeback.
// The slave modport is the ALU's view; the master modport is the producer/consumer side.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic             acc_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cy;
  logic             ov;

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, acc_sel, out_ready,
    output in_ready, out_valid, out, zr, ng, cy, ov
  );

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, acc_sel, out_ready,
    input  in_ready, out_valid, out, zr, ng, cy, ov
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack ALU with carry/overflow flags, accumulator operand and
// synchronous flush. S1 only captures the beat; S2 evaluates and registers result and flags.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input logic         clock,
  input logic         reset_n,
  input logic         clear,
  alu_pipe_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             cy;
    logic             ov;
  } res_t;

  // ctl packing: {zx, nx, zy, ny, f, no}; cy/ov are taken before the final inversion
  function automatic res_t alu_eval(input logic [WIDTH-1:0] xs,
                                    input logic [WIDTH-1:0] ys,
                                    input logic [5:0]       ctl);
    logic [WIDTH-1:0] xz;
    logic [WIDTH-1:0] yz;
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] ya;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   sum;
    res_t             res;
    xz  = ctl[5] ? {WIDTH{1'b0}} : xs;
    xa  = ctl[4] ? ~xz : xz;
    yz  = ctl[3] ? {WIDTH{1'b0}} : ys;
    ya  = ctl[2] ? ~yz : yz;
    sum = {1'b0, xa} + {1'b0, ya};
    if (ctl[1]) begin
      r      = sum[WIDTH-1:0];
      res.cy = sum[WIDTH];
      res.ov = (xa[WIDTH-1] == ya[WIDTH-1]) & (r[WIDTH-1] != xa[WIDTH-1]);
    end else begin
      r      = xa & ya;
      res.cy = 1'b0;
      res.ov = 1'b0;
    end
    res.out = ctl[0] ? ~r : r;
    res.zr  = (res.out == {WIDTH{1'b0}});
    res.ng  = res.out[WIDTH-1];
    return res;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [5:0]       ctl_q, ctl_d;
  logic             acc_sel_q, acc_sel_d;
  logic             s2_valid_q, s2_valid_d;
  res_t             res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_take_s;
  logic             in_ready_s;
  logic             accept_s;
  res_t             alu_res_s;

  // Handshake decode, S2 evaluation and next-state selection
  always_comb begin
    s2_take_s  = s1_valid_q & (~s2_valid_q | bus.out_ready);
    in_ready_s = reset_n & ~clear & (~s1_valid_q | s2_take_s);
    accept_s   = bus.in_valid & in_ready_s;
    alu_res_s  = alu_eval(acc_sel_q ? acc_q : x_q, y_q, ctl_q);

    s1_valid_d = s1_valid_q;
    x_d        = x_q;
    y_d        = y_q;
    ctl_d      = ctl_q;
    acc_sel_d  = acc_sel_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    acc_d      = acc_q;

    if (clear) begin
      // result regs keep their last value; only the valids and acc are flushed
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      acc_d      = {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        s1_valid_d = 1'b1;
        x_d        = bus.x;
        y_d        = bus.y;
        ctl_d      = {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no};
        acc_sel_d  = bus.acc_sel;
      end else if (s2_take_s) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end

      if (s2_take_s) begin
        s2_valid_d = 1'b1;
        res_d      = alu_res_s;
        acc_d      = alu_res_s.out;
      end else if (bus.out_ready) begin
        s2_valid_d = 1'b0;
      end else begin
        s2_valid_d = s2_valid_q;
      end
    end
  end

  // Pipeline state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      x_q        <= {WIDTH{1'b0}};
      y_q        <= {WIDTH{1'b0}};
      ctl_q      <= 6'b000000;
      acc_sel_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '{out: {WIDTH{1'b0}}, zr: 1'b0, ng: 1'b0, cy: 1'b0, ov: 1'b0};
      acc_q      <= {WIDTH{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ctl_q      <= ctl_d;
      acc_sel_q  <= acc_sel_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.out       = res_q.out;
  assign bus.zr        = res_q.zr;
  assign bus.ng        = res_q.ng;
  assign bus.cy        = res_q.cy;
  assign bus.ov        = res_q.ov;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe: the driver queues hand-computed results on
// acceptance and an independent monitor pops and compares on each output handshake.
module tb_alu_pipe;
  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] o;
    logic             zr;
    logic             ng;
    logic             cy;
    logic             ov;
  } res_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic clear   = 1'b0;

  alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  res_t exp_q[$];
  int   pop_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   cyc      = 0;
  logic bp_done  = 1'b0;
  logic [WIDTH-1:0] held;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic res_t mk(input logic [WIDTH-1:0] o, input logic zr, input logic ng,
                              input logic cy, input logic ov);
    res_t r;
    r.o = o; r.zr = zr; r.ng = ng; r.cy = cy; r.ov = ov;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation
  always @(negedge clock) begin
    res_t e;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%0h with no result pending", bus.out);
      end else begin
        e = exp_q.pop_front();
        check("result{out,zr,ng,cy,ov}", {44'd0, bus.out, bus.zr, bus.ng, bus.cy, bus.ov},
              {44'd0, e});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts the beat
  task automatic send(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                      input logic [5:0] ctl, input logic acc, input res_t e);
    bus.x = xv;
    bus.y = yv;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ctl;
    bus.acc_sel  = acc;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        n_acc++;
        @(posedge clock);
        #1;
        return;
      end
      @(posedge clock);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: in_ready never 1 for x=0x%0h y=0x%0h", xv, yv);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  localparam logic [5:0] ADD  = 6'b000010;
  localparam logic [5:0] AND  = 6'b000000;
  localparam logic [5:0] ADDN = 6'b000011;
  localparam logic [5:0] XMY  = 6'b010011;
  localparam logic [5:0] NEG1 = 6'b111010;

  initial begin
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.acc_sel = 1'b0;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b000000;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_flags", {bus.zr, bus.ng, bus.cy, bus.ov}, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Latency: not valid right after the accept edge, valid after the next one
    send(16'h0005, 16'h0003, ADD, 1'b0, mk(16'h0008, 0, 0, 0, 0));
    idle();
    check("latency_edge_n", bus.out_valid, 0);
    @(posedge clock);
    #1;
    check("latency_edge_n1", bus.out_valid, 1);

    send(16'h7FFF, 16'h0001, ADD,  1'b0, mk(16'h8000, 0, 1, 0, 1));
    send(16'hFFFF, 16'h0001, ADD,  1'b0, mk(16'h0000, 1, 0, 1, 0));
    send(16'd10,   16'd3,    XMY,  1'b0, mk(16'h0007, 0, 0, 0, 0));
    send(16'h1234, 16'h5678, NEG1, 1'b0, mk(16'hFFFF, 0, 1, 0, 0));
    send(16'h00FF, 16'h0F0F, AND,  1'b0, mk(16'h000F, 0, 0, 0, 0));
    send(16'hFFFF, 16'h0001, ADDN, 1'b0, mk(16'hFFFF, 0, 1, 1, 0));
    idle();
    drain();

    // Back-to-back accumulate: 1, 2, 3, 4 on consecutive cycles
    pop_cyc.delete();
    send(16'h0001, 16'h0000, ADD, 1'b0, mk(16'h0001, 0, 0, 0, 0));
    send(16'h0000, 16'h0001, ADD, 1'b1, mk(16'h0002, 0, 0, 0, 0));
    send(16'h0000, 16'h0001, ADD, 1'b1, mk(16'h0003, 0, 0, 0, 0));
    send(16'h0000, 16'h0001, ADD, 1'b1, mk(16'h0004, 0, 0, 0, 0));
    idle();
    drain();
    check("acc_pop_count", pop_cyc.size(), 4);
    if (pop_cyc.size() >= 4) check("acc_consecutive", pop_cyc[3] - pop_cyc[0], 3);

    // Backpressure: 4 beats offered while the consumer stalls for 5 cycles
    bus.out_ready = 1'b0;
    n_acc   = 0;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(WIDTH'(i), 16'd100, ADD, 1'b0, mk(WIDTH'(100 + i), 0, 0, 0, 0));
        idle();
        bp_done = 1'b1;
      end
    join_none
    held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 2) begin
        held = bus.out;
        check("bp_first_out", bus.out, 16'd100);
      end
      if (k > 2) check("bp_out_stable", bus.out, held);
    end
    check("bp_accepted", n_acc, 2);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && !bp_done; i++) @(posedge clock);
    #1;
    check("bp_driver_done", bp_done, 1);
    drain();
    check("bp_total_accepted", n_acc, 4);

    // clear with both stages full and a new beat offered
    bus.out_ready = 1'b0;
    send(16'h0001, 16'h0001, ADD, 1'b0, mk(16'h0002, 0, 0, 0, 0));
    send(16'h0002, 16'h0002, ADD, 1'b0, mk(16'h0004, 0, 0, 0, 0));
    bus.x = 16'h0009; bus.y = 16'h0009; bus.acc_sel = 1'b0;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ADD;
    bus.in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clock);
    check("clr_in_ready", bus.in_ready, 0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    idle();
    exp_q.delete();
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_out_held", bus.out, 16'h0002);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("clr_no_beat", bus.out_valid, 0);
    end
    @(posedge clock);
    #1;
    send(16'h0000, 16'h0005, ADD, 1'b1, mk(16'h0005, 0, 0, 0, 0));
    idle();
    drain();

    // Asynchronous reset mid-stream
    send(16'h0001, 16'h0002, ADD, 1'b0, mk(16'h0003, 0, 0, 0, 0));
    send(16'h0003, 16'h0004, ADD, 1'b0, mk(16'h0007, 0, 0, 0, 0));
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out", bus.out, 0);
    check("mid_rst_flags", {bus.zr, bus.ng, bus.cy, bus.ov}, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;
    send(16'h0002, 16'h0002, ADD, 1'b0, mk(16'h0004, 0, 0, 0, 0));
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised-width successor to the combinational Hack ALU.
- Same six control bits (zx, nx, zy, ny, f, no) and zr/ng flags, wrapped in a 2-stage registered pipeline with valid/ready handshakes on input and output.
- Adds carry/overflow flags, an accumulator mode (x replaced by the previous result) and a synchronous clear.
- Sits between the CPU decode stage and the writeback/register stage.

Parameters:
- WIDTH, 16, data width of x, y and out; legal values 4 to 64.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of pipeline and accumulator
- in_valid  in  1  operand/control beat offered
- in_ready  out  1  block accepts the beat this cycle
- x  in  WIDTH  operand x
- y  in  WIDTH  operand y
- zx, nx, zy, ny, f, no  in  1 each  Hack ALU control bits
- acc_sel  in  1  1 = use accumulator in place of x
- out_valid  out  1  result beat available
- out_ready  in  1  consumer accepts the result
- out  out  WIDTH  result
- zr  out  1  out == 0
- ng  out  1  out[WIDTH-1]
- cy  out  1  carry out of the add
- ov  out  1  signed overflow of the add

Behaviour:
- Reset (reset_n low, asynchronous): s1_valid=0, s2_valid=0, acc=0, out=0, zr=0, ng=0, cy=0, ov=0, out_valid=0. in_ready is 0 while reset_n is low.
- Stage 1 (S1) registers x, y, the control bits and acc_sel. No arithmetic is done in S1.
- Stage 2 (S2) computes and registers out and all flags; out_valid = s2_valid.
- Acceptance rules:
  - s2_take = s1_valid & (!s2_valid | out_ready)
  - in_ready = !clear & (!s1_valid | s2_take)
  - Input handshake occurs on in_valid & in_ready.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1. With out_ready held at 1, throughput is 1 beat/cycle.
- Backpressure: while out_valid & !out_ready, out/zr/ng/cy/ov are held stable. S1 keeps its beat, and in_ready drops once S1 is occupied.
- S2 computation, with xs = acc_sel ? acc : x_s1:
  1. xa = zx ? 0 : xs; if nx then xa = ~xa.
  2. ya = zy ? 0 : y_s1; if ny then ya = ~ya.
  3. If f=1: {c, r} = xa + ya, computed WIDTH+1 bits wide; cy = c; ov = (xa[MSB]==ya[MSB]) & (r[MSB]!=xa[MSB]).
  4. If f=0: r = xa & ya; cy = 0; ov = 0.
  5. out = no ? ~r : r. cy and ov are computed before the no inversion and are not affected by it.
  6. zr = (out == 0); ng = out[WIDTH-1]. Both are computed on the final out.
- Accumulator:
  - acc loads the new out value on every s2_take.
  - An acc_sel beat therefore always uses the result of the immediately preceding beat in program order, with no stall or hazard, including back-to-back beats.
  - acc resets to 0.
- clear (synchronous, high for one or more cycles):
  - Next edge: s1_valid=0, s2_valid=0, acc=0. out and the flags keep their old values but out_valid=0.
  - in_ready=0 in any cycle with clear=1, so clear beats a simultaneous in_valid.
  - A result being handshaked in the same cycle as clear counts as consumed.
- Wrap-around: addition is modulo 2^WIDTH; cy/ov report the wrap.
- Reset asserted mid-operation discards all in-flight beats immediately.
- No combinational path from x/y/control inputs to outputs. The only combinational path is out_ready -> in_ready.

Test Plan:
- WIDTH=16, x=0x0005, y=0x0003, f=1, all other controls 0, out_ready=1 -> out=0x0008, zr=0, ng=0, cy=0, ov=0, out_valid high 2 cycles after accept.
- x=0x7FFF, y=0x0001, f=1 -> out=0x8000, ng=1, ov=1, cy=0. Then x=0xFFFF, y=0x0001, f=1 -> out=0x0000, zr=1, cy=1, ov=0.
- Hack x-y encoding (zx=0, nx=1, zy=0, ny=0, f=1, no=1), x=10, y=3 -> out=7. With zx=1, nx=1, zy=1, ny=0, f=1, no=0 -> out=0xFFFF (-1), ng=1.
- Back-to-back accumulate: beat A x=1, y=0, f=1; beats B, C, D acc_sel=1, y=1, f=1, consecutive cycles -> outputs 1, 2, 3, 4 on consecutive cycles.
- Backpressure: hold out_ready=0 for 5 cycles while offering 4 beats -> exactly 2 accepted, then in_ready=0 and out stable. Release out_ready -> remaining beats drain in order with no loss or duplication.
- clear with S1 and S2 both full and in_valid=1 -> next cycle out_valid=0 and no beat accepted that cycle. Following acc_sel beat with y=5, f=1 -> out=5. Also: reset_n pulsed low mid-stream -> all outputs 0 immediately.
